// File: rtl/field_mul_arbiter.sv
// ---------------------------------------------------------------------------
// field_mul_arbiter
//
// Shares one multi-cycle, non-pipelined field multiplier among n_req
// requesters with round-robin arbitration. One operand pair is in flight
// at a time: the block grants a requester, launches the multiplier with a
// single-cycle mul_en, waits for mul_ready_pulse and then returns the
// product to the granted requester with a one-hot rsp_valid pulse.
//
// Ports
//   clk              rising-edge clock
//   rstb             synchronous, active-high reset
//   req_valid[k]     requester k has an operand pair (held until req_ack[k])
//   req_a / req_b    packed operands, requester k at [k*F +: F]
//   req_ack          one-hot, one-cycle: operands of requester k captured
//   rsp_valid        one-hot, one-cycle: rsp_c belongs to requester k
//   rsp_c            product, holds its value between responses
//   busy             high from grant until the response cycle (exclusive)
//   mul_en           one-cycle start pulse to the shared multiplier
//   mul_a / mul_b    registered operands to the multiplier
//   mul_ready_pulse  multiplier completion pulse
//   mul_c            multiplier result, sampled only on mul_ready_pulse
//
// The field width comes from field_arith_defs.v; the fallback below only
// applies when that header has not been compiled ahead of this file.
// ---------------------------------------------------------------------------
`ifndef F_NBITS
`define F_NBITS 32
`endif

module field_mul_arbiter #(
  parameter int n_req = 4
) (
  input  logic                        clk,
  input  logic                        rstb,
  input  logic [n_req-1:0]            req_valid,
  input  logic [n_req*`F_NBITS-1:0]   req_a,
  input  logic [n_req*`F_NBITS-1:0]   req_b,
  output logic [n_req-1:0]            req_ack,
  output logic [n_req-1:0]            rsp_valid,
  output logic [`F_NBITS-1:0]         rsp_c,
  output logic                        busy,
  output logic                        mul_en,
  output logic [`F_NBITS-1:0]         mul_a,
  output logic [`F_NBITS-1:0]         mul_b,
  input  logic                        mul_ready_pulse,
  input  logic [`F_NBITS-1:0]         mul_c
);

  localparam int ptr_bits = $clog2(n_req);
  localparam int fw       = `F_NBITS;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t              state_reg;
  logic [ptr_bits-1:0] rr_ptr_reg;
  logic [ptr_bits-1:0] owner_reg;
  logic [n_req-1:0]    req_ack_reg;
  logic [n_req-1:0]    rsp_valid_reg;
  logic [fw-1:0]       rsp_c_reg;
  logic                busy_reg;
  logic                mul_en_reg;
  logic [fw-1:0]       mul_a_reg;
  logic [fw-1:0]       mul_b_reg;

  // Unpacked views of the packed operand buses.
  logic [fw-1:0] op_a [n_req];
  logic [fw-1:0] op_b [n_req];

  // Candidate k is the requester k positions above rr_ptr, modulo n_req.
  logic [ptr_bits:0]   cand_sum [n_req];
  logic [ptr_bits-1:0] cand_idx [n_req];
  logic [n_req-1:0]    cand_hit;

  logic                grant_found;
  logic [ptr_bits-1:0] grant_idx;
  logic [ptr_bits-1:0] rr_ptr_next;

  genvar gi;
  generate
    for (gi = 0; gi < n_req; gi++) begin : g_slot
      assign op_a[gi] = req_a[gi*fw +: fw];
      assign op_b[gi] = req_b[gi*fw +: fw];

      // Sum is one bit wider than the pointer so the wrap test cannot overflow.
      assign cand_sum[gi] = {1'b0, rr_ptr_reg} + (ptr_bits+1)'(gi);
      assign cand_idx[gi] = (cand_sum[gi] >= (ptr_bits+1)'(n_req))
                            ? ptr_bits'(cand_sum[gi] - (ptr_bits+1)'(n_req))
                            : cand_sum[gi][ptr_bits-1:0];
      assign cand_hit[gi] = req_valid[cand_idx[gi]];
    end
  endgenerate

  // Lowest offset from rr_ptr wins: scan downward so the closest hit is
  // written last.
  always_comb begin
    grant_found = |cand_hit;
    grant_idx   = '0;
    for (int i = n_req - 1; i >= 0; i--) begin
      if (cand_hit[i]) begin
        grant_idx = cand_idx[i];
      end
    end
  end

  assign rr_ptr_next = (grant_idx == ptr_bits'(n_req - 1))
                       ? '0 : grant_idx + ptr_bits'(1);

  always_ff @(posedge clk) begin
    if (rstb) begin
      state_reg     <= IDLE;
      rr_ptr_reg    <= '0;
      owner_reg     <= '0;
      req_ack_reg   <= '0;
      rsp_valid_reg <= '0;
      rsp_c_reg     <= '0;
      busy_reg      <= 1'b0;
      mul_en_reg    <= 1'b0;
      mul_a_reg     <= '0;
      mul_b_reg     <= '0;
    end else begin
      // All pulse outputs default low; they are raised for exactly one cycle.
      req_ack_reg   <= '0;
      rsp_valid_reg <= '0;
      mul_en_reg    <= 1'b0;

      case (state_reg)
        IDLE: begin
          // A mul_ready_pulse seen here is stray and deliberately dropped.
          if (grant_found) begin
            owner_reg              <= grant_idx;
            mul_a_reg              <= op_a[grant_idx];
            mul_b_reg              <= op_b[grant_idx];
            req_ack_reg[grant_idx] <= 1'b1;
            mul_en_reg             <= 1'b1;
            busy_reg               <= 1'b1;
            rr_ptr_reg             <= rr_ptr_next;
            state_reg              <= WAIT;
          end
        end

        WAIT: begin
          // req_valid is ignored here, so a request held high across its
          // ack cannot be accepted twice.
          if (mul_ready_pulse) begin
            rsp_c_reg                <= mul_c;
            rsp_valid_reg[owner_reg] <= 1'b1;
            busy_reg                 <= 1'b0;
            state_reg                <= IDLE;
          end
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign req_ack   = req_ack_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_c     = rsp_c_reg;
  assign busy      = busy_reg;
  assign mul_en    = mul_en_reg;
  assign mul_a     = mul_a_reg;
  assign mul_b     = mul_b_reg;

endmodule

// File: tb/tb_field_mul_arbiter.sv
// ---------------------------------------------------------------------------
// tb_field_mul_arbiter
//
// Directed bench for field_mul_arbiter with n_req=4 and a behavioural
// multiplier of latency L=4. Outputs are sampled on the falling edge and
// inputs are changed there too, so they are picked up at the next rising
// edge.
// ---------------------------------------------------------------------------
`ifndef F_NBITS
`define F_NBITS 32
`endif

module tb_field_mul_arbiter;

  localparam int N = 4;
  localparam int F = `F_NBITS;
  localparam int L = 4;

  logic           clk;
  logic           rstb;
  logic [N-1:0]   req_valid;
  logic [N*F-1:0] req_a;
  logic [N*F-1:0] req_b;
  logic [N-1:0]   req_ack;
  logic [N-1:0]   rsp_valid;
  logic [F-1:0]   rsp_c;
  logic           busy;
  logic           mul_en;
  logic [F-1:0]   mul_a;
  logic [F-1:0]   mul_b;
  logic           mul_ready_pulse;
  logic [F-1:0]   mul_c;

  // Multiplier model plus a hook to inject stray completion pulses.
  logic         m_active;
  int           m_cnt;
  logic         m_ready;
  logic [F-1:0] m_c;
  logic         inject;
  logic [F-1:0] inject_c;

  int checks   = 0;
  int failures = 0;

  field_mul_arbiter #(.n_req(N)) dut (
    .clk             (clk),
    .rstb            (rstb),
    .req_valid       (req_valid),
    .req_a           (req_a),
    .req_b           (req_b),
    .req_ack         (req_ack),
    .rsp_valid       (rsp_valid),
    .rsp_c           (rsp_c),
    .busy            (busy),
    .mul_en          (mul_en),
    .mul_a           (mul_a),
    .mul_b           (mul_b),
    .mul_ready_pulse (mul_ready_pulse),
    .mul_c           (mul_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Ready is raised L cycles after the cycle in which mul_en was high.
  always @(posedge clk) begin
    if (rstb) begin
      m_active <= 1'b0;
      m_cnt    <= 0;
      m_ready  <= 1'b0;
      m_c      <= '0;
    end else begin
      m_ready <= 1'b0;
      if (mul_en) begin
        m_active <= 1'b1;
        m_cnt    <= L - 1;
        m_c      <= mul_a * mul_b;
      end else if (m_active) begin
        if (m_cnt == 1) begin
          m_ready  <= 1'b1;
          m_active <= 1'b0;
        end
        m_cnt <= m_cnt - 1;
      end
    end
  end

  assign mul_ready_pulse = m_ready | inject;
  assign mul_c           = inject ? inject_c : m_c;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rstb = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rstb = 1'b0;
  endtask

  task automatic wait_ack(output int idx);
    idx = -1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (req_ack != '0) begin
        for (int j = 0; j < N; j++) if (req_ack[j]) idx = j;
        break;
      end
    end
    if (idx < 0) begin
      checks++;
      failures++;
      $display("FAIL ack_timeout: got no req_ack required one within 20 cycles");
    end
  endtask

  task automatic wait_rsp(output logic [N-1:0] vec, output logic [F-1:0] c, output int acks);
    vec  = '0;
    c    = '0;
    acks = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (req_ack != '0) acks++;
      if (rsp_valid != '0) begin
        vec = rsp_valid;
        c   = rsp_c;
        break;
      end
    end
    if (vec == '0) begin
      checks++;
      failures++;
      $display("FAIL rsp_timeout: got no rsp_valid required one within 20 cycles");
    end
  endtask

  typedef struct {
    int           k;
    logic [F-1:0] a;
    logic [F-1:0] b;
    logic [F-1:0] c;
  } vec_t;

  vec_t vecs [4];

  initial begin
    int           idx;
    int           acks;
    logic [N-1:0] vec;
    logic [F-1:0] c;
    int           rr_order [5];
    logic [F-1:0] rr_c     [5];

    vecs[0] = '{k: 2, a: F'(3),        b: F'(5),    c: F'(15)};
    vecs[1] = '{k: 0, a: F'(100),      b: F'(200),  c: F'(20000)};
    vecs[2] = '{k: 3, a: F'(32'hFFFF), b: F'(2),    c: F'(32'h1FFFE)};
    vecs[3] = '{k: 1, a: F'(0),        b: F'(1234), c: F'(0)};

    rr_order = '{0, 1, 2, 3, 0};
    rr_c     = '{F'(7), F'(14), F'(21), F'(28), F'(7)};

    rstb      = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    inject    = 1'b0;
    inject_c  = '0;

    // ---- Reset then idle ----
    @(negedge clk);
    check("reset_outs", {req_ack, rsp_valid, rsp_c, busy, mul_en, mul_a, mul_b}, '0);
    @(negedge clk);
    rstb = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("idle_outs_%0d", i),
            {req_ack, rsp_valid, rsp_c, busy, mul_en, mul_a, mul_b}, '0);
    end
    inject   = 1'b1;
    inject_c = F'(999);
    @(negedge clk);
    inject = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("stray_pulse_idle_%0d", i), {rsp_valid, rsp_c, busy}, '0);
    end

    // ---- Single requests from the table: exact latency and slice choice ----
    for (int v = 0; v < 4; v++) begin
      for (int j = 0; j < N; j++) begin
        req_a[j*F +: F] = F'(32'hA000 + j);
        req_b[j*F +: F] = F'(32'hB000 + j);
      end
      req_a[vecs[v].k*F +: F] = vecs[v].a;
      req_b[vecs[v].k*F +: F] = vecs[v].b;
      req_valid = N'(1) << vecs[v].k;
      @(negedge clk);  // T+1
      check($sformatf("v%0d_ack", v), req_ack, N'(1) << vecs[v].k);
      check($sformatf("v%0d_mul_en", v), mul_en, 1'b1);
      check($sformatf("v%0d_mul_a", v), mul_a, vecs[v].a);
      check($sformatf("v%0d_mul_b", v), mul_b, vecs[v].b);
      check($sformatf("v%0d_busy_start", v), busy, 1'b1);
      req_valid = '0;
      for (int t = 2; t <= 5; t++) begin
        @(negedge clk);
        check($sformatf("v%0d_wait_T%0d", v, t),
              {busy, rsp_valid, mul_en, req_ack, mul_a, mul_b},
              {1'b1, N'(0), 1'b0, N'(0), vecs[v].a, vecs[v].b});
      end
      @(negedge clk);  // T+6
      check($sformatf("v%0d_rsp_valid", v), rsp_valid, N'(1) << vecs[v].k);
      check($sformatf("v%0d_rsp_c", v), rsp_c, vecs[v].c);
      check($sformatf("v%0d_busy_end", v), busy, 1'b0);
      @(negedge clk);  // T+7
      check($sformatf("v%0d_rsp_hold", v), {rsp_valid, rsp_c}, {N'(0), vecs[v].c});
    end

    // ---- Round-robin with all four requesters held valid ----
    do_reset();
    for (int j = 0; j < N; j++) begin
      req_a[j*F +: F] = F'(j + 1);
      req_b[j*F +: F] = F'(7);
    end
    req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_ack(idx);
      check($sformatf("rr_grant_%0d", i), idx, rr_order[i]);
      if (i == 4) req_valid = '0;
      wait_rsp(vec, c, acks);
      check($sformatf("rr_rsp_valid_%0d", i), vec, N'(1) << rr_order[i]);
      check($sformatf("rr_rsp_c_%0d", i), c, rr_c[i]);
    end

    // ---- Wrap from 3 to 0, then skip the idle requester 0 ----
    do_reset();
    req_valid = 4'b1000;
    wait_ack(idx);
    check("wrap_first", idx, 3);
    req_valid = '0;
    wait_rsp(vec, c, acks);
    check("wrap_first_rsp", {vec, c}, {4'b1000, F'(28)});
    req_valid = 4'b0110;
    wait_ack(idx);
    check("skip_grant_1", idx, 1);
    wait_rsp(vec, c, acks);
    check("skip_rsp_1", {vec, c}, {4'b0010, F'(14)});
    wait_ack(idx);
    check("skip_grant_2", idx, 2);
    req_valid = '0;
    wait_rsp(vec, c, acks);
    check("skip_rsp_2", {vec, c}, {4'b0100, F'(21)});

    // ---- Request arriving during WAIT, requester 0 kept valid ----
    do_reset();
    req_valid = 4'b0001;
    wait_ack(idx);
    check("wait_first_grant", idx, 0);
    @(negedge clk);
    req_valid = 4'b0101;
    wait_rsp(vec, c, acks);
    check("wait_no_ack", acks, 0);
    check("wait_rsp_0", {vec, c}, {4'b0001, F'(7)});
    wait_ack(idx);
    check("wait_next_grant", idx, 2);
    req_valid = 4'b0001;
    wait_rsp(vec, c, acks);
    check("wait_rsp_2", {vec, c}, {4'b0100, F'(21)});
    wait_ack(idx);
    check("wait_requeue_grant", idx, 0);
    req_valid = '0;
    wait_rsp(vec, c, acks);
    check("wait_rsp_0b", {vec, c}, {4'b0001, F'(7)});

    // ---- Reset in the middle of an operation ----
    do_reset();
    req_valid = 4'b0001;
    wait_ack(idx);
    check("midrst_grant", {idx[3:0], mul_en}, {4'd0, 1'b1});
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    rstb = 1'b1;
    @(negedge clk);
    check("midrst_outs", {req_ack, rsp_valid, busy, mul_en, mul_a, mul_b}, '0);
    rstb     = 1'b0;
    inject   = 1'b1;
    inject_c = F'(555);
    @(negedge clk);
    inject = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("midrst_no_rsp_%0d", i), {rsp_valid, busy}, '0);
    end
    // Pointer must be back at 0, so requester 0 wins over 1..3.
    req_valid = 4'b1111;
    wait_ack(idx);
    check("midrst_rr_ptr", idx, 0);
    req_valid = '0;
    wait_rsp(vec, c, acks);
    check("midrst_final_rsp", {vec, c}, {4'b0001, F'(7)});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
